// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding and response codes.
// Imported by every APB slave block in the codebase.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } apb_slave_fsm_states;

  localparam logic PSLVERR_OKAY  = 1'b0;
  localparam logic PSLVERR_ERROR = 1'b1;

endpackage

// File: rtl/apb_regbank.sv
// Register storage for the APB register file: ID, live status, and
// byte-lane-masked read/write registers 2..NUM_REGS-1.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            NUM_REGS = 16,
  parameter int            IW       = 4,
  parameter logic [DW-1:0] ID_VALUE = 'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IW-1:0]          idx,
  input  logic [DW-1:0]          wdata,
  input  logic [DW/8-1:0]        strb,
  input  logic [DW-1:0]          status,
  output logic [DW-1:0]          rdata,
  output logic [NUM_REGS*DW-1:0] image
);

  logic [DW-1:0] mem [2:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 2; k < NUM_REGS; k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      for (int k = 2; k < NUM_REGS; k++) begin
        if (idx == IW'(k)) begin
          for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) begin
              mem[k][b*8 +: 8] <= wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  assign image[DW-1:0]    = ID_VALUE;
  assign image[2*DW-1:DW] = status;

  for (genvar k = 2; k < NUM_REGS; k++) begin : g_img
    assign image[k*DW +: DW] = mem[k];
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == IW'(k)) begin
        rdata = image[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register file with fixed wait states: FSM, address decode
// and wait counter; storage lives in apb_regbank.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    PADDR_SIZE  = 10,
  parameter int                    PDATA_SIZE  = 8,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [PDATA_SIZE-1:0] ID_VALUE    = 'hA5
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [PADDR_SIZE-1:0]          PADDR,
  input  logic [PDATA_SIZE-1:0]          PWDATA,
  input  logic [PDATA_SIZE/8-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  output logic [PDATA_SIZE-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [PDATA_SIZE-1:0]          status_i,
  output logic [NUM_REGS*PDATA_SIZE-1:0] regs_o
);

  localparam int         SW      = PDATA_SIZE/8;
  localparam int         SHIFT   = $clog2(SW);
  localparam int         IW      = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  if (PDATA_SIZE % 8 != 0) begin : g_chk_dw
    $error("PDATA_SIZE must be a multiple of 8");
  end
  if (NUM_REGS < 3) begin : g_chk_nr
    $error("NUM_REGS must be at least 3");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_chk_wait
    $error("WAIT_CYCLES must be within 0..15");
  end

  apb_slave_fsm_states state;
  logic [3:0]            cnt;
  logic [PADDR_SIZE-1:0] addr_q;
  logic                  write_q;
  logic [PDATA_SIZE-1:0] wdata_q;
  logic [SW-1:0]         strb_q;

  logic                  setup;
  logic                  enter_resp;
  logic                  in_idle;
  logic [PADDR_SIZE-1:0] addr_c;
  logic                  write_c;
  logic [PDATA_SIZE-1:0] wdata_c;
  logic [SW-1:0]         strb_c;
  logic [PADDR_SIZE-1:0] idx;
  logic                  err;
  logic                  we;
  logic [PDATA_SIZE-1:0] rd_data;
  logic                  unused_pprot;

  assign unused_pprot = ^PPROT;
  assign setup        = PSEL & ~PENABLE;
  assign in_idle      = (state == ST_IDLE);

  // Zero-wait transfers respond straight from the setup phase inputs
  assign addr_c  = in_idle ? PADDR  : addr_q;
  assign write_c = in_idle ? PWRITE : write_q;
  assign wdata_c = in_idle ? PWDATA : wdata_q;
  assign strb_c  = in_idle ? PSTRB  : strb_q;

  assign idx = addr_c >> SHIFT;
  assign err = (idx >= PADDR_SIZE'(NUM_REGS)) ||
               (write_c && idx < PADDR_SIZE'(2));

  assign enter_resp =
    (in_idle && setup && WAIT_CYCLES == 0) ||
    (state == ST_ACCESS && PSEL && cnt == 4'd1);

  assign we = enter_resp & write_c & ~err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= PSLVERR_OKAY;
      PRDATA  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          PREADY  <= 1'b0;
          PSLVERR <= PSLVERR_OKAY;
          if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            cnt     <= WAIT_LD;
            state   <= (WAIT_CYCLES == 0) ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= PSLVERR_OKAY;
        end
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        PREADY  <= 1'b1;
        PSLVERR <= err ? PSLVERR_ERROR : PSLVERR_OKAY;
        PRDATA  <= (err || write_c) ? '0 : rd_data;
      end
    end
  end

  apb_regbank #(
    .DW       (PDATA_SIZE),
    .NUM_REGS (NUM_REGS),
    .IW       (IW),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .we     (we),
    .idx    (idx[IW-1:0]),
    .wdata  (wdata_c),
    .strb   (strb_c),
    .status (status_i),
    .rdata  (rd_data),
    .image  (regs_o)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: directed scenarios plus random transfers
// against a register-array reference model.
module tb_apb_slave_regfile;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         PSEL, PENABLE, PWRITE;
  logic [9:0]   PADDR;
  logic [7:0]   PWDATA;
  logic [0:0]   PSTRB;
  logic [2:0]   PPROT;
  logic [7:0]   PRDATA;
  logic         PREADY, PSLVERR;
  logic [7:0]   status_i;
  logic [127:0] regs_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] model [16];

  apb_slave_regfile dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PPROT    (PPROT),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .status_i (status_i),
    .regs_o   (regs_o)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] image();
    logic [127:0] img;
    for (int k = 0; k < 16; k++) img[k*8 +: 8] = model[k];
    img[7:0]  = 8'hA5;
    img[15:8] = status_i;
    return img;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 16; k++) model[k] = 8'h00;
  endtask

  task automatic xfer(input logic wr, input logic [9:0] a,
                      input logic [7:0] d, input logic s,
                      output logic [7:0] rd, output logic er,
                      output int n);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = a; PWDATA = d; PSTRB = s; PPROT = 3'($urandom);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 2;
    while (!PREADY && n < 20) begin
      @(posedge PCLK); #1;
      n++;
    end
    rd = PRDATA;
    er = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Transfer checked against the model's expected response and image
  task automatic do_xfer(input string tag, input logic wr,
                         input logic [9:0] a, input logic [7:0] d,
                         input logic s);
    logic [7:0] rd, exp_rd;
    logic       er, exp_er;
    int         n;
    exp_er = (a >= 10'd16) || (wr && a < 10'd2);
    if (exp_er || wr) exp_rd = 8'h00;
    else if (a == 10'd0) exp_rd = 8'hA5;
    else if (a == 10'd1) exp_rd = status_i;
    else exp_rd = model[a[3:0]];
    xfer(wr, a, d, s, rd, er, n);
    if (wr && !exp_er && s) model[a[3:0]] = d;
    check({tag, ".len"},  128'(n),  128'(4));
    check({tag, ".err"},  128'(er), 128'(exp_er));
    check({tag, ".data"}, 128'(rd), 128'(exp_rd));
    check({tag, ".regs"}, regs_o,   image());
  endtask

  initial begin
    int t0;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = 1'b1; PPROT = '0;
    status_i = 8'h00;
    clear_model();
    repeat (2) @(posedge PCLK);
    #1;
    check("rst.pready",  128'(PREADY),  128'(0));
    check("rst.pslverr", 128'(PSLVERR), 128'(0));
    check("rst.prdata",  128'(PRDATA),  128'(0));
    check("rst.regs",    regs_o,        image());
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    do_xfer("wr5", 1'b1, 10'd5, 8'h3C, 1'b1);
    do_xfer("rd5", 1'b0, 10'd5, 8'h00, 1'b1);
    check("rd5.slice", 128'(regs_o[47:40]), 128'(8'h3C));

    do_xfer("rd0",   1'b0, 10'd0, 8'h00, 1'b1);
    do_xfer("wr0",   1'b1, 10'd0, 8'h00, 1'b1);
    do_xfer("rd0b",  1'b0, 10'd0, 8'h00, 1'b1);

    status_i = 8'h71;
    do_xfer("rd1",  1'b0, 10'd1,  8'h00, 1'b1);
    do_xfer("rd16", 1'b0, 10'd16, 8'h00, 1'b1);

    do_xfer("wr7s0", 1'b1, 10'd7, 8'hFF, 1'b0);

    // Master drops PSEL in the second access cycle of a write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 10'd8; PWDATA = 8'h11; PSTRB = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      check("abort.pready", 128'(PREADY), 128'(0));
    end
    check("abort.r8", 128'(regs_o[71:64]), 128'(0));

    t0 = cyc;
    do_xfer("b2b2", 1'b1, 10'd2, 8'h22, 1'b1);
    do_xfer("b2b3", 1'b1, 10'd3, 8'h33, 1'b1);
    check("b2b.cycles", 128'(cyc - t0), 128'(8));

    // Reset pulse in the middle of a third write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 10'd4; PWDATA = 8'h55; PSTRB = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    check("rstmid.pready", 128'(PREADY),         128'(0));
    check("rstmid.r2",     128'(regs_o[23:16]),  128'(0));
    check("rstmid.r3",     128'(regs_o[31:24]),  128'(0));
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    clear_model();
    @(posedge PCLK); #1;
    check("rstmid.r4", 128'(regs_o[39:32]), 128'(0));
    check("rstmid.regs", regs_o, image());

    for (int i = 0; i < 40; i++) begin
      status_i = 8'($urandom);
      do_xfer("rnd", 1'($urandom), 10'($urandom_range(0, 19)),
              8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter PADDR_SIZE, default 10, APB address width.
REQ-002 Parameter PDATA_SIZE, default 8, APB data width; multiple of 8.
REQ-003 Parameter NUM_REGS, default 16, number of PDATA_SIZE-wide registers; minimum 3.
REQ-004 Parameter WAIT_CYCLES, default 2, PREADY-low access cycles per transfer; range 0..15.
REQ-005 Parameter ID_VALUE, default 'hA5, reset-independent constant returned by register 0.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 PCLK  in  1  clock; all state on rising edge.
REQ-008 PRESETn  in  1  asynchronous active-low reset.
REQ-009 PSEL  in  1  slave select.
REQ-010 PENABLE  in  1  access phase.
REQ-011 PWRITE  in  1  1=write, 0=read.
REQ-012 PADDR  in  PADDR_SIZE  byte address.
REQ-013 PWDATA  in  PDATA_SIZE  write data.
REQ-014 PSTRB  in  PDATA_SIZE/8  write byte-lane enables.
REQ-015 PPROT  in  3  protection; accepted, ignored.
REQ-016 PRDATA  out  PDATA_SIZE  registered read data.
REQ-017 PREADY  out  1  registered transfer-complete.
REQ-018 PSLVERR  out  1  registered error, valid only while PREADY=1.
REQ-019 status_i  in  PDATA_SIZE  live value returned by read-only register 1.
REQ-020 regs_o  out  NUM_REGS*PDATA_SIZE  flat register image; slice k = register k (k=0 ID, k=1 status_i).

Function
REQ-021 Register index = PADDR >> log2(PDATA_SIZE/8); low PADDR bits below that are ignored.
REQ-022 FSM states ST_IDLE, ST_ACCESS, ST_RESP; ST_IDLE after reset.
REQ-023 ST_IDLE: on PSEL=1 & PENABLE=0 latch PADDR, PWRITE, PWDATA, PSTRB, load wait counter with WAIT_CYCLES; go ST_RESP if WAIT_CYCLES=0, else ST_ACCESS.
REQ-024 ST_ACCESS: decrement counter each cycle; on edge where counter=1 go ST_RESP; PREADY=0 throughout.
REQ-025 Entry into ST_RESP registers PREADY=1, PSLVERR, PRDATA; transfer length = 2+WAIT_CYCLES cycles from setup.
REQ-026 ST_RESP: exactly one cycle; next state ST_IDLE with PREADY=0, PSLVERR=0; back-to-back setup in the following cycle is accepted without a gap.
REQ-027 Error when index >= NUM_REGS, or write to index 0 or 1; error reads return PRDATA=0.
REQ-028 Valid read: PRDATA = ID_VALUE (index 0), status_i sampled on the ST_RESP entry edge (index 1), stored register otherwise.
REQ-029 Valid write updates only lanes with PSTRB=1, at the ST_RESP entry edge; PSTRB=0 write completes OKAY with no change.
REQ-030 Erroring writes never modify storage.
REQ-031 PSEL deasserted in ST_ACCESS: abort to ST_IDLE, no write, PREADY stays 0.
REQ-032 PRDATA holds last value outside ST_RESP; cleared to 0 on error or write completion.

Reset
REQ-033 PRESETn low, any state: ST_IDLE, counter 0, PREADY=0, PSLVERR=0, PRDATA=0, RW registers (2..NUM_REGS-1) = 0, immediately and asynchronously.
REQ-034 Reset mid-transfer discards the transfer; no partial write.

Structure
REQ-035 Shared package apb_pkg holds the apb_slave_fsm_states enum and PSLVERR_OKAY/PSLVERR_ERROR constants, alongside existing ahb3lite_pkg.
REQ-036 Storage and lane-masked write logic in one sub-module apb_regbank; FSM, decode, counter in the top.
REQ-037 Elaboration assertions: PDATA_SIZE%8==0, NUM_REGS>=3, WAIT_CYCLES<=15.

Verification (PDATA_SIZE=8, PADDR_SIZE=10, NUM_REGS=16, WAIT_CYCLES=2, ID_VALUE='hA5)
REQ-038 Write 'h3C to addr 5, then read addr 5 -> each transfer PREADY high exactly on 4th cycle from setup, PSLVERR=0, PRDATA='h3C, regs_o[47:40]='h3C.
REQ-039 Read addr 0 -> PRDATA='hA5; write 'h00 to addr 0 -> PSLVERR=1, subsequent read still 'hA5.
REQ-040 status_i='h71, read addr 1 -> PRDATA='h71; read addr 16 -> PSLVERR=1, PRDATA=0.
REQ-041 Write 'hFF to addr 7 with PSTRB=0 -> OKAY, register 7 stays 0; PSEL dropped in 2nd access cycle of write 'h11 to addr 8 -> no PREADY, register 8 stays 0.
REQ-042 Back-to-back writes addr 2,3 with no idle cycle -> both complete, 8 cycles total; PRESETn pulsed during a 3rd write -> PREADY=0, regs 2,3 = 0.
